// File: rtl/pc_seg_pkg.sv
// pc_seg_pkg: shared types and sizing for the program-counter stage
package pc_seg_pkg;
   typedef enum logic [2:0] {SEL_SEQ, SEL_BR, SEL_JMP, SEL_RET, SEL_HOLD} next_sel_t;
   localparam int RAS_DEPTH_DEF = 4;
   localparam int RAS_PTR_W = $clog2(RAS_DEPTH_DEF);
endpackage

// File: rtl/pc_ras_stack.sv
// pc_ras_stack: circular return-address LIFO; a push when full overwrites the oldest entry
module pc_ras_stack
   import pc_seg_pkg::*;
#(
   parameter int W = 32,
   parameter int DEPTH = RAS_DEPTH_DEF,
   parameter int PTR_W = RAS_PTR_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] top,
   output logic         empty,
   output logic         full
);
   logic [W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] top_ptr;
   logic [PTR_W:0] count;
   assign top_ptr = ptr - PTR_W'(1);
   assign top = mem[top_ptr];
   assign empty = count == '0;
   assign full = count == (PTR_W+1)'(DEPTH);
   // write pointer and occupancy; pointer wraps so the oldest slot is reused on overflow
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr <= '0;
         count <= '0;
      end else if (push) begin
         ptr <= ptr + PTR_W'(1);
         if (!full) count <= count + (PTR_W+1)'(1);
      end else if (pop) begin
         ptr <= top_ptr;
         count <= count - (PTR_W+1)'(1);
      end
   end
   // entry storage needs no reset; contents only matter once pushed
   always_ff @(posedge clk) begin
      if (push) mem[ptr] <= din;
   end
endmodule

// File: rtl/pc_seg_unit.sv
// pc_seg_unit: next-PC selection, PC register and return-address stack for the fetch path
module pc_seg_unit
   import pc_seg_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int INC = 1,
   parameter int JUMP_W = 28,
   parameter logic [ADDR_W-1:0] RESET_VEC = '0,
   parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              branch_cond,
   input  logic              zero,
   input  logic [ADDR_W-1:0] ext_imm,
   input  logic              jump,
   input  logic [JUMP_W-1:0] instr_target,
   input  logic              call,
   input  logic              ret,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_plus,
   output logic              redirect,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ras_underflow
);
   next_sel_t sel;
   logic [ADDR_W-1:0] ras_top;
   logic [ADDR_W-1:0] next_pc;
   logic push;
   logic pop;
   assign pc_plus = pc + ADDR_W'(INC);
   // redirects outrank stall; a ret on an empty stack falls back to sequential
   always_comb begin
      sel = ret ? (ras_empty ? SEL_SEQ : SEL_RET) :
            jump ? SEL_JMP :
            (branch_cond & zero) ? SEL_BR :
            stall ? SEL_HOLD : SEL_SEQ;
      next_pc = sel == SEL_RET ? ras_top :
                sel == SEL_JMP ? {pc_plus[ADDR_W-1:JUMP_W], instr_target} :
                sel == SEL_BR ? pc_plus + ext_imm :
                sel == SEL_HOLD ? pc : pc_plus;
   end
   assign redirect = sel == SEL_RET || sel == SEL_JMP || sel == SEL_BR;
   assign push = jump & call & ~ret;
   assign pop = sel == SEL_RET;
   pc_ras_stack #(
      .W(ADDR_W),
      .DEPTH(RAS_DEPTH),
      .PTR_W($clog2(RAS_DEPTH))
   ) u_ras (
      .clk(clk),
      .reset(reset),
      .push(push),
      .pop(pop),
      .din(pc_plus),
      .top(ras_top),
      .empty(ras_empty),
      .full(ras_full)
   );
   // PC register and one-cycle underflow pulse
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc <= RESET_VEC;
         ras_underflow <= 1'b0;
      end else begin
         pc <= next_pc;
         ras_underflow <= ret & ras_empty;
      end
   end
endmodule

// File: tb/tb_pc_seg_unit.sv
// tb_pc_seg_unit: directed vector table plus hand sequences for pc_seg_unit
module tb_pc_seg_unit;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic stall = 1'b0, branch_cond = 1'b0, zero = 1'b0, jump = 1'b0, call = 1'b0, ret = 1'b0;
   logic [31:0] ext_imm = '0;
   logic [27:0] instr_target = '0;
   logic [31:0] pc, pc_plus;
   logic redirect, ras_empty, ras_full, ras_underflow;
   int tests = 0;
   int fails = 0;

   pc_seg_unit #(.ADDR_W(32), .INC(1), .JUMP_W(28), .RESET_VEC(32'h0), .RAS_DEPTH(4)) dut (
      .clk(clk), .reset(reset), .stall(stall), .branch_cond(branch_cond), .zero(zero),
      .ext_imm(ext_imm), .jump(jump), .instr_target(instr_target), .call(call), .ret(ret),
      .pc(pc), .pc_plus(pc_plus), .redirect(redirect), .ras_empty(ras_empty),
      .ras_full(ras_full), .ras_underflow(ras_underflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic s, b, z;
      logic [31:0] imm;
      logic j;
      logic [27:0] t;
      logic c, r;
      logic [31:0] p;
      logic rd, e, f, u;
   } vec_t;

   function automatic vec_t mk(logic s, b, z, logic [31:0] imm, logic j, logic [27:0] t,
                               logic c, r, logic [31:0] p, logic rd, e, f, u);
      vec_t v;
      v.s = s; v.b = b; v.z = z; v.imm = imm; v.j = j; v.t = t; v.c = c; v.r = r;
      v.p = p; v.rd = rd; v.e = e; v.f = f; v.u = u;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(vec_t v);
      stall = v.s; branch_cond = v.b; zero = v.z; ext_imm = v.imm;
      jump = v.j; instr_target = v.t; call = v.c; ret = v.r;
   endtask

   vec_t vecs [38];
   vec_t idle;

   initial begin
      logic [31:0] prev;
      idle = mk(0,0,0,0,0,0,0,0,0,0,0,0,0);
      vecs[0]  = mk(0,0,0,0,0,0,0,0, 32'd1,0,1,0,0);
      vecs[1]  = mk(0,0,0,0,0,0,0,0, 32'd2,0,1,0,0);
      vecs[2]  = mk(0,0,0,0,0,0,0,0, 32'd3,0,1,0,0);
      vecs[3]  = mk(0,0,0,0,0,0,0,0, 32'd4,0,1,0,0);
      vecs[4]  = mk(0,0,0,0,0,0,0,0, 32'd5,0,1,0,0);
      vecs[5]  = mk(0,1,1,32'hFFFF_FFFD,0,0,0,0, 32'd3,1,1,0,0);
      vecs[6]  = mk(0,0,0,0,0,0,0,0, 32'd4,0,1,0,0);
      vecs[7]  = mk(0,0,0,0,0,0,0,0, 32'd5,0,1,0,0);
      vecs[8]  = mk(0,1,0,32'hFFFF_FFFD,0,0,0,0, 32'd6,0,1,0,0);
      vecs[9]  = mk(0,0,0,0,0,0,0,0, 32'd7,0,1,0,0);
      vecs[10] = mk(0,0,0,0,0,0,0,0, 32'd8,0,1,0,0);
      vecs[11] = mk(1,0,0,0,0,0,0,0, 32'd8,0,1,0,0);
      vecs[12] = mk(1,0,0,0,0,0,0,0, 32'd8,0,1,0,0);
      vecs[13] = mk(1,0,0,0,0,0,0,0, 32'd8,0,1,0,0);
      vecs[14] = mk(1,1,1,32'd2,0,0,0,0, 32'd11,1,1,0,0);
      vecs[15] = mk(0,1,1,32'h1000_0004,0,0,0,0, 32'h1000_0010,1,1,0,0);
      vecs[16] = mk(0,0,0,0,1,28'h40,1,0, 32'h1000_0040,1,0,0,0);
      vecs[17] = mk(0,0,0,0,0,0,0,1, 32'h1000_0011,1,1,0,0);
      vecs[18] = mk(0,0,0,0,0,0,0,1, 32'h1000_0012,0,1,0,1);
      vecs[19] = mk(0,0,0,0,0,0,0,0, 32'h1000_0013,0,1,0,0);
      vecs[20] = mk(0,0,0,0,1,28'hA,0,0, 32'h1000_000A,1,1,0,0);
      vecs[21] = mk(0,0,0,0,1,28'hB,1,0, 32'h1000_000B,1,0,0,0);
      vecs[22] = mk(0,0,0,0,1,28'hC,1,0, 32'h1000_000C,1,0,0,0);
      vecs[23] = mk(0,0,0,0,1,28'hD,1,0, 32'h1000_000D,1,0,0,0);
      vecs[24] = mk(0,0,0,0,1,28'hE,1,0, 32'h1000_000E,1,0,1,0);
      vecs[25] = mk(0,0,0,0,1,28'hF,1,0, 32'h1000_000F,1,0,1,0);
      vecs[26] = mk(0,0,0,0,0,0,0,1, 32'h1000_000F,1,0,0,0);
      vecs[27] = mk(0,0,0,0,0,0,0,1, 32'h1000_000E,1,0,0,0);
      vecs[28] = mk(0,0,0,0,0,0,0,1, 32'h1000_000D,1,0,0,0);
      vecs[29] = mk(0,0,0,0,0,0,0,1, 32'h1000_000C,1,1,0,0);
      vecs[30] = mk(0,0,0,0,0,0,0,1, 32'h1000_000D,0,1,0,1);
      vecs[31] = mk(0,0,0,0,0,0,0,0, 32'h1000_000E,0,1,0,0);
      vecs[32] = mk(0,0,0,0,1,28'h50,1,1, 32'h1000_000F,0,1,0,1);
      vecs[33] = mk(0,0,0,0,1,28'h20,1,0, 32'h1000_0020,1,0,0,0);
      vecs[34] = mk(0,0,0,0,1,28'h30,1,1, 32'h1000_0010,1,1,0,0);
      vecs[35] = mk(0,0,0,0,0,0,1,0, 32'h1000_0011,0,1,0,0);
      vecs[36] = mk(0,1,1,32'hEFFF_FFED,0,0,0,0, 32'hFFFF_FFFF,1,1,0,0);
      vecs[37] = mk(0,0,0,0,0,0,0,0, 32'h0000_0000,0,1,0,0);

      #8;
      chk("reset pc", pc, 32'h0);
      chk("reset ras_empty", 32'(ras_empty), 32'd1);
      chk("reset ras_full", 32'(ras_full), 32'd0);
      chk("reset underflow", 32'(ras_underflow), 32'd0);
      #4 reset = 1'b1;
      prev = 32'h0;
      for (int i = 0; i < 38; i++) begin
         drive(vecs[i]);
         #1;
         chk($sformatf("v%0d pc_plus", i), pc_plus, prev + 32'd1);
         chk($sformatf("v%0d redirect", i), 32'(redirect), 32'(vecs[i].rd));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d pc", i), pc, vecs[i].p);
         chk($sformatf("v%0d ras_empty", i), 32'(ras_empty), 32'(vecs[i].e));
         chk($sformatf("v%0d ras_full", i), 32'(ras_full), 32'(vecs[i].f));
         chk($sformatf("v%0d underflow", i), 32'(ras_underflow), 32'(vecs[i].u));
         prev = vecs[i].p;
      end

      drive(mk(0,0,0,0,1,28'h100,1,0,0,0,0,0,0));
      @(posedge clk);
      #1;
      chk("pre-reset pc", pc, 32'h100);
      chk("pre-reset ras_empty", 32'(ras_empty), 32'd0);
      drive(idle);
      #2 reset = 1'b0;
      #1;
      chk("async reset pc", pc, 32'h0);
      chk("async reset ras_empty", 32'(ras_empty), 32'd1);
      chk("async reset underflow", 32'(ras_underflow), 32'd0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      chk("first fetch after reset", pc, 32'h0);
      ret = 1'b1;
      #1;
      chk("ret after reset redirect", 32'(redirect), 32'd0);
      @(posedge clk);
      #1;
      chk("ret after reset pc", pc, 32'h1);
      chk("ret after reset underflow", 32'(ras_underflow), 32'd1);
      ret = 1'b0;
      @(posedge clk);
      #1;
      chk("underflow pulse end", 32'(ras_underflow), 32'd0);
      chk("seq after underflow pc", pc, 32'h2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
